// File: rtl/synth_pkg.sv
// Shared types and defaults for the synthesizer core's reset/control blocks.
package synth_pkg;

  typedef enum logic [1:0] {
    StHold,
    StWaitRdy,
    StRun,
    StDrain
  } seq_state_e;

  localparam int unsigned SeqCntW = 22;

  // At 50 MHz: roughly 21 ms hold per stage and 84 ms ready timeout.
  localparam logic [SeqCntW-1:0] SeqDelayDefault   = 22'h0FFFFF;
  localparam logic [SeqCntW-1:0] SeqTimeoutDefault = 22'h3FFFFF;

endpackage

// File: rtl/rst_req_collector.sv
// Soft-reset request bookkeeping: accumulates requests into a pending mask, moves
// pending to served when a sequence starts, and pulses the served mask as an ack.
module rst_req_collector #(
  parameter int unsigned NReq = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [NReq-1:0] req_i,
  input  logic            snap_i,      // sequence starts: take the pending snapshot
  input  logic            ack_fire_i,  // sequence completes: ack what was served
  output logic            pend_any_o,
  output logic [NReq-1:0] ack_o
);

  logic [NReq-1:0] pend_q, pend_d;
  logic [NReq-1:0] served_q, served_d;
  logic [NReq-1:0] ack_q, ack_d;

  // Next-state for pending/served masks and the one-cycle ack pulse.
  always_comb begin
    pend_d   = pend_q | req_i;
    served_d = served_q;
    ack_d    = '0;
    if (snap_i) begin
      // Requests arriving in the snapshot cycle stay pending for the next sequence.
      served_d = pend_q;
      pend_d   = req_i;
    end
    if (ack_fire_i) begin
      ack_d    = served_q;
      served_d = '0;
    end
  end

  // Request registers; a reset discards everything outstanding.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q   <= '0;
      served_q <= '0;
      ack_q    <= '0;
    end else begin
      pend_q   <= pend_d;
      served_q <= served_d;
      ack_q    <= ack_d;
    end
  end

  assign pend_any_o = |pend_q;
  assign ack_o      = ack_q;

endmodule

// File: rtl/rst_sequencer.sv
// Staged reset controller: releases NSTAGE reset domains in order with a hold delay
// and a bounded ready handshake each, and replays the sequence on soft-reset requests.
module rst_sequencer
  import synth_pkg::*;
#(
  parameter int unsigned      NSTAGE  = 3,
  parameter int unsigned      NREQ    = 4,
  parameter int unsigned      CNT_W   = SeqCntW,
  parameter logic [CNT_W-1:0] DELAY   = CNT_W'(SeqDelayDefault),
  parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(SeqTimeoutDefault)
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [NSTAGE-1:0] iSTAGE_RDY,
  input  logic [NREQ-1:0]   iREQ,
  output logic [NSTAGE-1:0] oRST,
  output logic [NREQ-1:0]   oACK,
  output logic              oBUSY,
  output logic              oFAULT
);

  localparam int unsigned      IdxW        = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
  localparam logic [IdxW-1:0]  IdxLast     = IdxW'(NSTAGE - 1);
  localparam logic [CNT_W-1:0] DelayLast   = DELAY - CNT_W'(1);
  localparam logic [CNT_W-1:0] TimeoutLast = TIMEOUT - CNT_W'(1);

  seq_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [NSTAGE-1:0] rst_q, rst_d;
  logic              fault_q, fault_d;
  logic              snap, ack_fire, pend_any, stage_done;

  rst_req_collector #(
    .NReq(NREQ)
  ) u_req (
    .clk_i     (iCLK),
    .rst_ni    (iRST),
    .req_i     (iREQ),
    .snap_i    (snap),
    .ack_fire_i(ack_fire),
    .pend_any_o(pend_any),
    .ack_o     (oACK)
  );

  // Sequencing FSM: next state, counter, stage index, stage resets and fault.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    rst_d      = rst_q;
    fault_d    = fault_q;
    snap       = 1'b0;
    ack_fire   = 1'b0;
    stage_done = 1'b0;
    unique case (state_q)
      StHold: begin
        if (cnt_q == DelayLast) begin
          rst_d[idx_q] = 1'b1;
          cnt_d        = '0;
          state_d      = StWaitRdy;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StWaitRdy: begin
        // Ready beats a simultaneous timeout, leaving the fault flag alone.
        if (iSTAGE_RDY[idx_q]) begin
          stage_done = 1'b1;
        end else if (cnt_q == TimeoutLast) begin
          fault_d    = 1'b1;
          stage_done = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (stage_done) begin
          cnt_d = '0;
          if (idx_q == IdxLast) begin
            state_d  = StRun;
            ack_fire = 1'b1;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            state_d = StHold;
          end
        end
      end
      StRun: begin
        if (pend_any) begin
          snap    = 1'b1;
          fault_d = 1'b0;
          idx_d   = IdxLast;
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Re-assert stages in reverse order, one per cycle.
        rst_d[idx_q] = 1'b0;
        if (idx_q == '0) begin
          cnt_d   = '0;
          state_d = StHold;
        end else begin
          idx_d = idx_q - IdxW'(1);
        end
      end
      default: state_d = StHold;
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q <= StHold;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      fault_q <= fault_d;
    end
  end

  assign oRST   = rst_q;
  assign oFAULT = fault_q;
  assign oBUSY  = (state_q != StRun);

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer with NSTAGE=3, DELAY=4, TIMEOUT=8.
module tb_rst_sequencer;

  localparam int NS  = 3;
  localparam int NR  = 4;
  localparam int DLY = 4;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NS-1:0] rdy = '1;
  logic [NR-1:0] req = '0;
  logic [NS-1:0] o_rst;
  logic [NR-1:0] o_ack;
  logic          o_busy, o_fault;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  rst_sequencer #(
    .NSTAGE (NS),
    .NREQ   (NR),
    .CNT_W  (22),
    .DELAY  (22'd4),
    .TIMEOUT(22'd8)
  ) dut (
    .iCLK      (clk),
    .iRST      (rst_n),
    .iSTAGE_RDY(rdy),
    .iREQ      (req),
    .oRST      (o_rst),
    .oACK      (o_ack),
    .oBUSY     (o_busy),
    .oFAULT    (o_fault)
  );

  always #5 clk = ~clk;

  // Edges seen since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Tracks how many stages are up, hold/wait progress, and remaining drain steps.
  int          m_up = 0, m_hold = 0, m_wait = 0, m_drain = 0;
  bit          m_waiting = 0, m_run = 0, m_fault = 0;
  logic [NS-1:0] m_rst = '0;
  logic [NR-1:0] m_pend = '0, m_served = '0, m_ack = '0;

  task automatic model_reset();
    m_up = 0; m_hold = 0; m_wait = 0; m_drain = 0;
    m_waiting = 0; m_run = 0; m_fault = 0;
    m_rst = '0; m_pend = '0; m_served = '0; m_ack = '0;
  endtask

  always @(posedge clk or negedge rst_n) begin : model
    logic [NR-1:0] nxt_pend, nxt_ack;
    bit done;
    if (!rst_n) begin
      model_reset();
    end else begin
      nxt_pend = m_pend | req;
      nxt_ack  = '0;
      done     = 0;
      if (m_drain > 0) begin
        m_rst[m_drain-1] = 1'b0;
        m_drain--;
        if (m_drain == 0) begin m_up = 0; m_hold = 0; end
      end else if (m_run) begin
        if (m_pend != 0) begin
          m_served = m_pend;
          nxt_pend = req;
          m_fault  = 0;
          m_run    = 0;
          m_drain  = NS;
        end
      end else if (!m_waiting) begin
        m_hold++;
        if (m_hold == DLY) begin
          m_rst[m_up] = 1'b1;
          m_waiting   = 1;
          m_wait      = 0;
        end
      end else begin
        m_wait++;
        if (rdy[m_up]) done = 1;
        else if (m_wait == TMO) begin m_fault = 1; done = 1; end
        if (done) begin
          m_waiting = 0;
          m_up++;
          m_hold = 0;
          if (m_up == NS) begin
            m_run    = 1;
            nxt_ack  = m_served;
            m_served = '0;
          end
        end
      end
      m_ack  = nxt_ack;
      m_pend = nxt_pend;
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en)
      check("cycle", 32'({o_rst, o_ack, o_busy, o_fault}),
            32'({m_rst, m_ack, !m_run, m_fault}));
  end

  // ---------------- helpers ----------------
  function automatic logic [3:0] cur(input int sel);
    case (sel)
      0:       return 4'(o_rst);
      1:       return {3'b0, o_busy};
      2:       return {3'b0, o_fault};
      default: return o_ack;
    endcase
  endfunction

  // Wait (bounded) at negedges until the selected output equals val; returns cyc.
  task automatic wait_cond(input string name, input int sel, input logic [3:0] val,
                           output int at);
    bit hit = 0;
    at = -1;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (cur(sel) == val) begin hit = 1; at = cyc; end
    end
    if (!hit) begin
      n_total++;
      $display("FAIL %s: timed out, last value %h, required %h", name, cur(sel), val);
    end
  endtask

  task automatic pulse_req(input logic [NR-1:0] v);
    req = v;
    @(negedge clk);
    req = '0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int a0, a1, a2, c0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_state", 32'({o_rst, o_ack, o_busy, o_fault}), 32'({3'b000, 4'b0000, 1'b1, 1'b0}));

    // T1: power-up, all stages ready immediately.
    rst_n = 1'b1;
    wait_cond("t1_s0", 0, 4'b0001, a0); check("t1_rise0_cyc", a0, 4);
    wait_cond("t1_s1", 0, 4'b0011, a0); check("t1_rise1_cyc", a0, 9);
    wait_cond("t1_s2", 0, 4'b0111, a0); check("t1_rise2_cyc", a0, 14);
    wait_cond("t1_busy", 1, 4'b0000, a0); check("t1_busy_fall_cyc", a0, 15);
    check("t1_ack_fault", 32'({o_ack, o_fault}), 32'(0));

    // T2: stage 1 never ready -> timeout and fault, sequence continues.
    rdy = 3'b101;
    pulse_req(4'b0010);
    wait_cond("t2_drained", 0, 4'b0000, a0);
    wait_cond("t2_s1", 0, 4'b0011, a0);
    wait_cond("t2_fault", 2, 4'b0001, a1); check("t2_fault_delay", a1 - a0, TMO);
    wait_cond("t2_s2", 0, 4'b0111, a2);    check("t2_s2_delay", a2 - a1, DLY);
    wait_cond("t2_ack", 3, 4'b0010, a0);
    check("t2_run_fault", 32'({o_busy, o_fault}), 32'(2'b01));

    // T3: one-cycle request in RUN -> reverse drain then re-release; fault cleared.
    rdy = 3'b111;
    pulse_req(4'b0001);
    check("t3_pending", 32'(o_rst), 32'(3'b111));
    @(negedge clk); check("t3_drain_entry", 32'({o_rst, o_busy}), 32'(4'b1111));
    @(negedge clk); check("t3_drain1", 32'(o_rst), 32'(3'b011));
    @(negedge clk); check("t3_drain2", 32'(o_rst), 32'(3'b001));
    @(negedge clk); check("t3_drain3", 32'(o_rst), 32'(3'b000)); c0 = cyc;
    wait_cond("t3_s0", 0, 4'b0001, a0); check("t3_rerise_delay", a0 - c0, DLY);
    wait_cond("t3_ack", 3, 4'b0001, a0);
    check("t3_fault_clear", 32'(o_fault), 32'(0));

    // T4: requests during DRAIN and HOLD are served together by the next sequence.
    pulse_req(4'b0001);
    @(negedge clk);
    pulse_req(4'b0010);
    repeat (3) @(negedge clk);
    pulse_req(4'b0100);
    wait_cond("t4_ack_first", 3, 4'b0001, a0);
    wait_cond("t4_ack_second", 3, 4'b0110, a1);
    check("t4_ack_spacing", a1 - a0, 19);

    // T5: reset mid-WAIT_RDY with a request pending.
    rdy = 3'b000;
    pulse_req(4'b0001);
    wait_cond("t5_drained", 0, 4'b0000, a0);
    wait_cond("t5_s0", 0, 4'b0001, a0);
    pulse_req(4'b1000);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("t5_async_reset", 32'({o_rst, o_ack, o_busy, o_fault}), 32'(8'b0000_0010));
    rdy = 3'b111;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_cond("t5_s2", 0, 4'b0111, a0); check("t5_rise2_cyc", a0, 14);
    wait_cond("t5_busy", 1, 4'b0000, a0);
    check("t5_no_ack", 32'(o_ack), 32'(0));

    // T6: level request held -> back-to-back sequences, one ack each.
    req = 4'b1111;
    wait_cond("t6_ack1", 3, 4'b1111, a0);
    wait_cond("t6_ack2", 3, 4'b1111, a1); check("t6_period_a", a1 - a0, 19);
    wait_cond("t6_ack3", 3, 4'b1111, a2); check("t6_period_b", a2 - a1, 19);
    req = 4'b0000;
    wait_cond("t6_ack4", 3, 4'b1111, a0); check("t6_period_c", a0 - a2, 19);
    repeat (30) @(negedge clk);
    check("t6_idle", 32'({o_rst, o_ack, o_busy}), 32'(8'b111_0000_0));

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
